// File: rtl/pipeline_controller.sv
// pipeline_controller: run/step/halt sequencing, load-use stalls, control flushes and debug counters
module pipeline_controller #(
  parameter int NB_REG       = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_id_halt,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic              i_ex_memRead,
  input  logic              i_id_branch_taken,
  input  logic              i_id_jump,
  output logic              o_pipe_en,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_cycle_cnt,
  output logic [NB_CNT-1:0] o_stall_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DRAIN, S_HALTED} state_t;
  state_t r_state, w_next;
  logic [2:0] r_drain;
  logic [NB_CNT-1:0] r_cycle, r_stall;
  logic w_active, w_drain, w_stall, w_halt, w_ctl;
  always_comb begin
    w_active      = r_state == S_RUN || r_state == S_STEP;
    w_drain       = r_state == S_DRAIN;
    w_stall       = w_active && i_ex_memRead && i_ex_rt != '0 &&
                    (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
    w_halt        = w_active && !w_stall && i_id_halt;
    w_ctl         = w_active && !w_stall && (i_id_branch_taken || i_id_jump);
    o_pipe_en     = w_active || w_drain;
    o_pc_we       = w_active && !w_stall && !w_halt;
    o_ifid_we     = (w_active && !w_stall) || w_drain;
    o_ifid_flush  = w_drain || w_ctl || w_halt;
    o_idex_bubble = w_stall || w_halt;
    o_halted      = r_state == S_HALTED;
    o_cycle_cnt   = r_cycle;
    o_stall_cnt   = r_stall;
    w_next        = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : i_step ? S_STEP : S_IDLE;
      S_RUN:   w_next = w_halt ? S_DRAIN : S_RUN;
      S_STEP:  w_next = w_halt ? S_DRAIN : S_IDLE;
      S_DRAIN: w_next = r_drain == 3'd1 ? S_HALTED : S_DRAIN;
      default: w_next = S_HALTED;
    endcase
  end
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_drain <= '0;
      r_cycle <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      if (w_halt) r_drain <= 3'(DRAIN_CYCLES);
      else if (w_drain) r_drain <= r_drain - 3'd1;
      if (o_pipe_en) r_cycle <= r_cycle + NB_CNT'(1);
      if (w_stall) r_stall <= r_stall + NB_CNT'(1);
    end
  end
endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencing and hazard controller for the 5-stage MIPS pipeline. Gates pipeline advance through run, single-step and halt modes. Detects load-use hazards and inserts bubbles. Flushes IF/ID on taken branches and jumps. Drains in-flight instructions on HALT, and exposes cycle and stall counters to the debug unit. Sits between the debug unit, the ID-stage decode/control logic, and the write enables of PC, IF/ID and ID/EX.

## Interface
Parameters:
- NB_REG, 5, register-address width
- NB_CNT, 32, width of cycle/stall counters
- DRAIN_CYCLES, 3, cycles the pipeline keeps advancing after HALT is accepted (range 1..7)

Ports:
- clk  in  1  single clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  debug unit: begin continuous run (level, sampled in IDLE)
- i_step  in  1  debug unit: one-cycle pulse, advance pipeline one cycle
- i_id_halt  in  1  HALT opcode decoded in ID
- i_id_rs  in  NB_REG  rs of instruction in ID
- i_id_rt  in  NB_REG  rt of instruction in ID
- i_ex_rt  in  NB_REG  rt of instruction in EX
- i_ex_memRead  in  1  instruction in EX is a load
- i_id_branch_taken  in  1  branch resolved taken in ID
- i_id_jump  in  1  jump decoded in ID
- o_pipe_en  out  1  global advance enable for all pipeline registers
- o_pc_we  out  1  PC write enable
- o_ifid_we  out  1  IF/ID write enable
- o_ifid_flush  out  1  clear IF/ID to NOP on next edge
- o_idex_bubble  out  1  load NOP into ID/EX on next edge
- o_halted  out  1  pipeline halted and drained
- o_cycle_cnt  out  NB_CNT  count of advanced cycles
- o_stall_cnt  out  NB_CNT  count of load-use stall cycles

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Registered state; reset → IDLE.
- IDLE: o_pipe_en=0. i_start=1 → RUN. Otherwise i_step=1 → STEP. i_start wins if both are high.
- RUN: o_pipe_en=1 every cycle. An accepted halt → DRAIN.
- STEP: o_pipe_en=1 for exactly one cycle. Then → IDLE, or → DRAIN if halt accepted in that cycle.
- DRAIN: o_pipe_en=1, o_pc_we=0, o_ifid_flush=1 every cycle. A down-counter loaded with DRAIN_CYCLES decrements each cycle; at 1 → HALTED. Drain runs automatically. i_step/i_start are ignored.
- HALTED: o_pipe_en=0, o_halted=1. Exit only via i_rst.
- Hazard logic applies only in RUN and STEP. All enables below are 0 when o_pipe_en=0.
- Load-use stall when i_ex_memRead && i_ex_rt!=0 && (i_ex_rt==i_id_rs || i_ex_rt==i_id_rt):
  - o_pc_we=0, o_ifid_we=0, o_idex_bubble=1, o_ifid_flush=0.
- Control flush when no stall and (i_id_branch_taken || i_id_jump):
  - o_ifid_flush=1, o_pc_we=1.
- Stall has priority over flush and halt. A stalled branch, jump or HALT is re-evaluated next cycle.
- Halt accepted when i_id_halt && no stall:
  - o_idex_bubble=1 (HALT itself becomes NOP), o_pc_we=0, o_ifid_flush=1.
- Default in RUN/STEP: o_pc_we=1, o_ifid_we=1, o_ifid_flush=0, o_idex_bubble=0.
- o_cycle_cnt increments on every edge with o_pipe_en=1.
- o_stall_cnt increments on every edge where a load-use stall is asserted.
- Both counters wrap modulo 2^NB_CNT and clear only on reset.

## Timing
- Enables and hazard outputs are combinational from registered state and current inputs. They take effect at the next rising edge.
- i_start high at edge k (in IDLE) → RUN; o_pipe_en=1 from cycle k+1.
- i_step pulse at edge k → exactly one advanced edge (k+1). A held i_step re-steps every 2 cycles (STEP→IDLE→STEP).
- Halt accepted in cycle T → o_halted=1 from cycle T+DRAIN_CYCLES+1. o_cycle_cnt includes the T cycle and all drain cycles.
- i_rst asserted mid-operation (any state, including DRAIN) → immediately IDLE. All outputs 0, counters 0, drain counter 0.
- Reset values: every output 0.

## Test plan
- Reset, then i_start=1: o_pipe_en=1 and o_pc_we=1 from the cycle after start; o_cycle_cnt=10 after 10 run cycles.
- RUN with i_ex_memRead=1, i_ex_rt=8, i_id_rs=8 for 1 cycle: o_pc_we=0, o_ifid_we=0, o_idex_bubble=1; o_stall_cnt=1. Repeat with i_ex_rt=0: no stall.
- RUN with i_id_branch_taken=1 and a simultaneous load-use match: only the stall is asserted. Next cycle, with the hazard gone and the branch still taken: o_ifid_flush=1, o_pc_we=1.
- i_id_halt=1 in RUN with DRAIN_CYCLES=3 at cycle T: o_idex_bubble=1 at T; o_pipe_en=1 at T+1..T+3 with o_pc_we=0; o_halted=1 and o_pipe_en=0 from T+4. i_start is then ignored.
- From IDLE, three i_step pulses 4 cycles apart: o_cycle_cnt=3, o_pipe_en high exactly 3 cycles. i_start and i_step together in IDLE → RUN.
- Assert i_rst during DRAIN: all outputs 0 asynchronously; after release the controller sits in IDLE with counters 0.
